// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: depth computation and default pointer geometry.
package async_fifo_pkg;

  localparam int unsigned DefPtrWidth = 2;

  // FIFO depth for a given number of address bits; pointers carry one extra wrap bit.
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int unsigned Width = 3
) (
  input  logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_status_flags.sv
// Write-domain full / almost-full / level generator with look-ahead on this cycle's accepted write.
// Optional overflow flag and saturating counter are built when WR_STATUS_OVERFLOW_EN is defined.
module wr_status_flags
  import async_fifo_pkg::*;
#(
  parameter int unsigned PtrWidth    = DefPtrWidth,
  parameter int unsigned OvfCntWidth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PtrWidth:0]      i_wr_bin_ptr,
  input  logic                   i_wr_en,
  input  logic [PtrWidth:0]      i_rd_gray_ptr_sync,
  input  logic [PtrWidth:0]      i_afull_thresh,
  input  logic                   i_ovf_clr,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic [PtrWidth:0]      o_wr_level,
  output logic                   o_overflow,
  output logic [OvfCntWidth-1:0] o_ovf_count
);

  localparam int unsigned PtrW  = PtrWidth + 1;
  localparam int unsigned Depth = fifo_depth(PtrWidth);

  logic [PtrW-1:0] rd_bin;
  logic [PtrW-1:0] wr_next;
  logic [PtrW-1:0] level_next;
  logic            push;

  gray2bin #(.Width(PtrW)) u_gray2bin (
    .gray (i_rd_gray_ptr_sync),
    .bin  (rd_bin)
  );

  // Look-ahead level: modular pointer difference after this cycle's push.
  always_comb begin
    push       = i_wr_en & ~o_full;
    wr_next    = i_wr_bin_ptr + PtrW'(push);
    level_next = wr_next - rd_bin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_level    <= '0;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
    end else begin
      o_wr_level    <= level_next;
      o_full        <= (level_next == PtrW'(Depth));
      o_almost_full <= (level_next >= i_afull_thresh);
    end
  end

`ifdef WR_STATUS_OVERFLOW_EN
  logic ovf_evt;

  assign ovf_evt = i_wr_en & o_full;

  // Sticky flag and saturating count; a simultaneous event beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_ovf_count <= '0;
    end else begin
      if (ovf_evt) begin
        o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        o_overflow <= 1'b0;
      end
      if (i_ovf_clr) begin
        o_ovf_count <= OvfCntWidth'(ovf_evt);
      end else if (ovf_evt && (o_ovf_count != {OvfCntWidth{1'b1}})) begin
        o_ovf_count <= o_ovf_count + OvfCntWidth'(1);
      end
    end
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = i_ovf_clr;
  assign o_overflow     = 1'b0;
  assign o_ovf_count    = '0;
`endif

endmodule
